// File: rtl/ifetch_mux_1_pkg.sv
// Shared fetch-stage definitions for the MIPS datapath.
// Covers the word width, the reset PC and the PC-select encodings.
package ifetch_mux_1_pkg;

  localparam int          WORD_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic {
    SEL_SEQ      = 1'b0,
    SEL_REDIRECT = 1'b1
  } sel_e;

endpackage

// File: rtl/ifetch_mux_1_mux2_w.sv
// Width-parameterised combinational 2:1 mux.
// Anything other than a clean 1 on sel (0, X, Z) falls back to a.
module mux2_w #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] y
);

  // if/else rather than ?: so an unknown select resolves to a, not an X-merge
  always_comb begin
    y = a;
    if (sel == 1'b1) begin
      y = b;
    end
  end

endmodule

// File: rtl/ifetch_mux_1.sv
// Fetch-stage PC selector: sequential PC vs redirect target, with a
// zero-latency result for the PC path and a registered copy plus redirect flag.
module ifetch_mux_1
  import ifetch_mux_1_pkg::*;
#(
  parameter int               WIDTH       = WORD_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = RESET_PC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] op0,
  input  logic [WIDTH-1:0] op1,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] mux_out1,
  output logic [WIDTH-1:0] mux_q,
  output logic             sel_q
);

  logic is_redirect;

  mux2_w #(
    .W(WIDTH)
  ) u_mux (
    .a  (op0),
    .b  (op1),
    .sel(sel),
    .y  (mux_out1)
  );

  // Mirrors the mux decision so an unknown select records as sequential
  always_comb begin
    is_redirect = 1'b0;
    if (sel == SEL_REDIRECT) begin
      is_redirect = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux_q <= RESET_VALUE;
      sel_q <= 1'b0;
    end else if (en) begin
      mux_q <= mux_out1;
      sel_q <= is_redirect;
    end
  end

endmodule

// File: tb/tb_ifetch_mux_1.sv
// Directed bench for ifetch_mux_1: immediate combinational checks plus a
// scoreboard of expected registered state popped one cycle after each drive.
module tb_ifetch_mux_1;
  import ifetch_mux_1_pkg::*;

  localparam int W = WORD_W;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] op0;
  logic [W-1:0] op1;
  logic         sel;
  logic         en;
  logic [W-1:0] mux_out1;
  logic [W-1:0] mux_q;
  logic         sel_q;

  typedef struct packed {
    logic [W-1:0] q;
    logic         s;
  } reg_t;

  reg_t sb_q[$];
  reg_t model;
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;

  ifetch_mux_1 #(
    .WIDTH      (W),
    .RESET_VALUE(RESET_PC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .op0     (op0),
    .op1     (op1),
    .sel     (sel),
    .en      (en),
    .mux_out1(mux_out1),
    .mux_q   (mux_q),
    .sel_q   (sel_q)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive inputs, check the combinational path at once, queue the registered expectation
  task automatic applyStimulus(input string tag, input logic [W-1:0] o0, input logic [W-1:0] o1,
                               input logic s, input logic e);
    logic [W-1:0] exp_mux;
    op0 = o0;
    op1 = o1;
    sel = s;
    en  = e;
    exp_mux = (s === 1'b1) ? o1 : o0;
    #1;
    checkOutput({tag, "_mux_out1"}, mux_out1, exp_mux);
    if (rst) begin
      model.q = RESET_PC;
      model.s = 1'b0;
    end else if (e) begin
      model.q = exp_mux;
      model.s = (s === SEL_REDIRECT);
    end
    sb_q.push_back(model);
  endtask

  task automatic stepCycle(input string tag);
    reg_t exp;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp = sb_q.pop_front();
      checkOutput({tag, "_mux_q"}, mux_q, exp.q);
      checkOutput({tag, "_sel_q"}, {{(W-1){1'b0}}, sel_q}, {{(W-1){1'b0}}, exp.s});
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    op0 = '0;
    op1 = '0;
    sel = 1'b0;
    en  = 1'b0;
    model = '{q: RESET_PC, s: 1'b0};
    #2;
    checkOutput("rst_mux_out1", mux_out1, 32'h0);
    checkOutput("rst_mux_q", mux_q, 32'h0);
    checkOutput("rst_sel_q", {{(W-1){1'b0}}, sel_q}, 32'h0);

    @(negedge clk);
    rst = 1'b0;

    applyStimulus("sel0", 32'h5555_5555, 32'haaaa_aaaa, 1'b0, 1'b1);
    stepCycle("sel0");

    applyStimulus("sel1", 32'h5555_5555, 32'haaaa_aaaa, 1'b1, 1'b1);
    stepCycle("sel1");

    for (int i = 0; i < 3; i++) begin
      applyStimulus("hold", 32'h1234_5678, 32'haaaa_aaaa, 1'b0, 1'b0);
      stepCycle("hold");
    end

    // Asynchronous reset raised between edges
    #2;
    rst = 1'b1;
    #1;
    model = '{q: RESET_PC, s: 1'b0};
    checkOutput("arst_mux_q", mux_q, 32'h0);
    checkOutput("arst_sel_q", {{(W-1){1'b0}}, sel_q}, 32'h0);
    applyStimulus("arst", 32'h5555_5555, 32'haaaa_aaaa, 1'b1, 1'b1);
    stepCycle("arst");
    rst = 1'b0;

    applyStimulus("selx", 32'h5555_5555, 32'haaaa_aaaa, 1'bx, 1'b1);
    stepCycle("selx");

    for (int i = 0; i < 24; i++) begin
      applyStimulus("rand", $urandom, $urandom, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
      stepCycle("rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
